// File: rtl/fir_pkg.sv
// Shared FIR definitions: geometry, Q-format constants and the
// round-half-up / saturate step used on the sink side of the FIR.
package fir_pkg;

  localparam int FIR_TAPS   = 16;
  localparam int SAMPLE_W   = 16;
  localparam int ACC_W      = 36;
  localparam int FRAC_SHIFT = 15;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  // One conditioned sample plus a flag telling whether it was clamped.
  typedef struct packed {
    logic                       sat;
    logic signed [SAMPLE_W-1:0] sample;
  } cond_sample_t;

  // Round a Q2.30 accumulator to Q1.15 (half toward +inf), then clamp.
  // The add is one bit wider than the accumulator so it cannot wrap.
  function automatic cond_sample_t round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] rnd;
    cond_sample_t          res;
    sum = $signed({acc[ACC_W-1], acc}) + $signed((ACC_W+1)'(1) << (FRAC_SHIFT - 1));
    rnd = sum >>> FRAC_SHIFT;
    if (rnd > $signed((ACC_W+1)'(SAT_MAX))) begin
      res.sat    = 1'b1;
      res.sample = SAT_MAX;
    end else if (rnd < $signed({{(ACC_W-SAMPLE_W+1){1'b1}}, SAT_MIN})) begin
      res.sat    = 1'b1;
      res.sample = SAT_MIN;
    end else begin
      res.sat    = 1'b0;
      res.sample = rnd[SAMPLE_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO. The head entry is visible on 'head' whenever
// 'empty' is low. A push into a full FIFO is accepted when a pop happens on
// the same edge; the freed slot is the one being written.
module fir_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fir_output_conditioner.sv
// Sink-side conditioner for the weighted FIR: discards warm-up samples,
// rounds/saturates the wide sum to Q1.15, decimates, and queues results.
//
// Output handshake: a sample transfers on every rising edge where
// out_valid and out_ready are both high. out_valid depends only on FIFO
// state (never on out_ready), and out_ready is ignored while out_valid is
// low. The input side has no ready: the FIR cannot stall, so a kept sample
// that finds the FIFO full (and not popping) is dropped and 'overflow' set.
module fir_output_conditioner
  import fir_pkg::*;
#(
  parameter int DECIM      = 4,
  parameter int WARMUP     = fir_pkg::FIR_TAPS - 1,
  parameter int FIFO_DEPTH = 8,
  parameter int IN_W       = fir_pkg::ACC_W,
  parameter int OUT_W      = fir_pkg::SAMPLE_W,
  parameter int FRAC_SHIFT = fir_pkg::FRAC_SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_sample,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sample,
  output logic             overflow,
  output logic [15:0]      sat_count,
  input  logic             status_clr
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0]       WARM_LIM   = CNT_W'(WARMUP);
  localparam logic [CNT_W-1:0]       PHASE_LAST = CNT_W'(DECIM - 1);
  localparam logic signed [IN_W:0]   HALF       = (IN_W+1)'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [IN_W:0]   R_MAX      = (IN_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [IN_W:0]   R_MIN      = ~R_MAX;

  // Front-end counters.
  logic [CNT_W-1:0] warm_cnt;
  logic [CNT_W-1:0] phase;
  logic             warm_done;
  logic             keep;

  // Rounding / saturation datapath.
  logic signed [IN_W:0]  sum_ext;
  logic signed [IN_W:0]  rnd;
  logic                  sat_hi;
  logic                  sat_lo;
  logic [OUT_W-1:0]      cond_val;

  // Stage 1 register.
  logic             s1_valid;
  logic             s1_sat;
  logic [OUT_W-1:0] s1_sample;

  // FIFO side.
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             fifo_push;
  logic             drop;
  logic [OUT_W-1:0] fifo_head;
  logic [OUT_W-1:0] last_q;

  assign warm_done = (warm_cnt == WARM_LIM);
  assign keep      = in_valid & warm_done & (phase == '0);

  assign sum_ext  = $signed({in_sample[IN_W-1], in_sample}) + HALF;
  assign rnd      = sum_ext >>> FRAC_SHIFT;
  assign sat_hi   = (rnd > R_MAX);
  assign sat_lo   = (rnd < R_MIN);
  assign cond_val = sat_hi ? R_MAX[OUT_W-1:0] :
                    sat_lo ? R_MIN[OUT_W-1:0] : rnd[OUT_W-1:0];

  // Warm-up counter saturates at WARMUP; phase then cycles 0..DECIM-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt <= '0;
      phase    <= '0;
    end else if (in_valid) begin
      if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
      else            phase    <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
    end
  end

  // Stage 1 captures each kept sample with its clamp flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sat    <= 1'b0;
      s1_sample <= '0;
    end else begin
      s1_valid <= keep;
      if (keep) begin
        s1_sat    <= sat_hi | sat_lo;
        s1_sample <= cond_val;
      end
    end
  end

  assign fifo_pop  = out_ready & ~fifo_empty;
  assign fifo_push = s1_valid & (~fifo_full | fifo_pop);
  assign drop      = s1_valid & fifo_full & ~fifo_pop;

  fir_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (s1_sample),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sticky overflow and saturating clamp counter; clear wins over any update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      sat_count <= '0;
    end else if (status_clr) begin
      overflow  <= 1'b0;
      sat_count <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (s1_valid && s1_sat && (sat_count != 16'hFFFF)) sat_count <= sat_count + 1'b1;
    end
  end

  // Remember the last popped head so out_sample holds while the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           last_q <= '0;
    else if (fifo_pop) last_q <= fifo_head;
  end

  assign out_valid  = ~fifo_empty;
  assign out_sample = fifo_empty ? last_q : fifo_head;

endmodule

// File: tb/tb_fir_output_conditioner.sv
// Bench for fir_output_conditioner. Instance A uses the default warm-up and
// decimation; instance B runs with WARMUP=0, DECIM=1 for the arithmetic and
// FIFO corner cases. Monitors pop expected samples as the DUTs emit them.
module tb_fir_output_conditioner;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        a_in_valid, a_out_valid, a_out_ready, a_overflow, a_status_clr;
  logic [35:0] a_in_sample;
  logic [15:0] a_out_sample, a_sat_count;
  logic        b_in_valid, b_out_valid, b_out_ready, b_overflow, b_status_clr;
  logic [35:0] b_in_sample;
  logic [15:0] b_out_sample, b_sat_count;

  fir_output_conditioner #(
    .DECIM(4), .WARMUP(15), .FIFO_DEPTH(8), .IN_W(36), .OUT_W(16), .FRAC_SHIFT(15)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .in_valid(a_in_valid), .in_sample(a_in_sample),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sample(a_out_sample),
    .overflow(a_overflow), .sat_count(a_sat_count), .status_clr(a_status_clr)
  );

  fir_output_conditioner #(
    .DECIM(1), .WARMUP(0), .FIFO_DEPTH(8), .IN_W(36), .OUT_W(16), .FRAC_SHIFT(15)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .in_valid(b_in_valid), .in_sample(b_in_sample),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sample(b_out_sample),
    .overflow(b_overflow), .sat_count(b_sat_count), .status_clr(b_status_clr)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];
  int checks = 0;
  int errors = 0;
  int a_first_cyc = -1;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] s36(input longint v);
    return v[35:0];
  endfunction

  function automatic logic [15:0] e16(input int v);
    return v[15:0];
  endfunction

  // Monitor A: outputs sampled on the falling edge, popped on handshake.
  always @(negedge clk) begin
    if (!rst_a && a_out_valid) begin
      if (a_first_cyc < 0) a_first_cyc = cyc;
      if (a_out_ready) begin
        if (exp_a_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected: got %0d expected no output", $signed(a_out_sample));
        end else begin
          check("a_sample", a_out_sample, exp_a_q.pop_front());
        end
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (!rst_b && b_out_valid && b_out_ready) begin
      if (exp_b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got %0d expected no output", $signed(b_out_sample));
      end else begin
        check("b_sample", b_out_sample, exp_b_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic a_send(input logic [35:0] s, input logic rdy);
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_sample = s; a_out_ready = rdy;
  endtask

  task automatic a_idle(input int n, input logic rdy);
    repeat (n) begin
      @(posedge clk); #1;
      a_in_valid = 1'b0; a_out_ready = rdy;
    end
  endtask

  task automatic b_send(input logic [35:0] s, input logic rdy);
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_sample = s; b_out_ready = rdy;
  endtask

  task automatic b_idle(input int n, input logic rdy);
    repeat (n) begin
      @(posedge clk); #1;
      b_in_valid = 1'b0; b_out_ready = rdy;
    end
  endtask

  task automatic b_clr_pulse();
    @(posedge clk); #1; b_status_clr = 1'b1;
    @(posedge clk); #1; b_status_clr = 1'b0;
  endtask

  task automatic wait_drain_a(input int budget);
    int i = 0;
    while (exp_a_q.size() != 0 && i < budget) begin
      @(posedge clk); i++;
    end
    check("a_drain_left", 36'(exp_a_q.size()), 36'd0);
  endtask

  task automatic wait_drain_b(input int budget);
    int i = 0;
    while (exp_b_q.size() != 0 && i < budget) begin
      @(posedge clk); i++;
    end
    check("b_drain_left", 36'(exp_b_q.size()), 36'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timed out");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t15;
    rst_a = 1'b1; rst_b = 1'b1;
    a_in_valid = 1'b0; a_in_sample = '0; a_out_ready = 1'b0; a_status_clr = 1'b0;
    b_in_valid = 1'b0; b_in_sample = '0; b_out_ready = 1'b0; b_status_clr = 1'b0;
    t15 = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("a_rst_valid",    a_out_valid,  0);
    check("a_rst_sample",   a_out_sample, 0);
    check("a_rst_overflow", a_overflow,   0);
    check("a_rst_satcnt",   a_sat_count,  0);
    check("b_rst_valid",    b_out_valid,  0);
    check("b_rst_satcnt",   b_sat_count,  0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Warm-up + decimation: kept inputs 15,19,...,39
    for (int v = 15; v < 40; v += 4) exp_a_q.push_back(e16(v));
    for (int n = 0; n < 40; n++) begin
      a_send(s36(longint'(n) <<< 15), 1'b1);
      if (n == 15) t15 = cyc;
    end
    a_idle(1, 1'b1);
    wait_drain_a(50);
    check("a_latency", 36'(a_first_cyc - t15), 36'd2);
    a_idle(3, 1'b1);
    check("a_idle_valid",   a_out_valid,  0);
    check("a_hold_sample",  a_out_sample, 39);
    check("a_overflow_0",   a_overflow,   0);
    check("a_satcnt_0",     a_sat_count,  0);

    // Reset mid-stream: 15 warm-up + 18 post-warm-up inputs -> 5 queued, phase 2
    @(posedge clk); #1; rst_a = 1'b1; #2; rst_a = 1'b0;
    for (int i = 0; i < 33; i++) a_send(s36(longint'(500 + i) <<< 15), 1'b0);
    a_idle(3, 1'b0);
    check("a_prerst_valid",  a_out_valid,  1);
    check("a_prerst_head",   a_out_sample, 515);
    @(posedge clk); #3; rst_a = 1'b1; #1;
    check("a_rst_async_valid",  a_out_valid,  0);
    check("a_rst_async_sample", a_out_sample, 0);
    #2; rst_a = 1'b0;
    exp_a_q.push_back(e16(1015));
    exp_a_q.push_back(e16(1019));
    for (int k = 0; k < 20; k++) a_send(s36(longint'(1000 + k) <<< 15), 1'b1);
    a_idle(1, 1'b1);
    wait_drain_a(50);
    a_idle(3, 1'b1);
    check("a_post_rst_idle", a_out_valid, 0);

    // Rounding
    exp_b_q.push_back(e16(0));
    exp_b_q.push_back(e16(1));
    exp_b_q.push_back(e16(0));
    exp_b_q.push_back(e16(-1));
    exp_b_q.push_back(e16(2));
    b_send(s36(16383), 1'b1);
    b_send(s36(16384), 1'b1);
    b_send(s36(-16384), 1'b1);
    b_send(s36(-16385), 1'b1);
    b_send(s36(49152), 1'b1);
    b_idle(1, 1'b1);
    wait_drain_b(50);
    check("b_round_satcnt", b_sat_count, 0);

    // Saturation
    exp_b_q.push_back(16'h7FFF);
    exp_b_q.push_back(16'h8000);
    b_send(s36(longint'(1) <<< 30), 1'b1);
    b_send(s36(-(longint'(1) <<< 30) - 32768), 1'b1);
    b_idle(1, 1'b1);
    wait_drain_b(50);
    check("b_sat_count2", b_sat_count, 2);
    exp_b_q.push_back(16'h8000);
    b_send(s36(-(longint'(1) <<< 30)), 1'b1);
    b_idle(1, 1'b1);
    wait_drain_b(50);
    check("b_sat_nocount", b_sat_count, 2);
    b_clr_pulse();
    check("b_sat_cleared", b_sat_count, 0);

    // Overflow: 10 kept samples into an 8-deep FIFO with no consumer
    for (int v = 1; v <= 8; v++) exp_b_q.push_back(e16(v));
    for (int v = 1; v <= 10; v++) b_send(s36(longint'(v) <<< 15), 1'b0);
    b_idle(3, 1'b0);
    check("b_ovf_set",   b_overflow,   1);
    check("b_ovf_valid", b_out_valid,  1);
    check("b_ovf_head",  b_out_sample, 1);
    b_idle(1, 1'b1);
    wait_drain_b(50);
    b_idle(3, 1'b1);
    check("b_ovf_drained", b_out_valid, 0);
    check("b_ovf_sticky",  b_overflow,  1);
    b_clr_pulse();
    check("b_ovf_cleared", b_overflow, 0);

    // Full FIFO with simultaneous pop: 21..28 fill, 29 arrives as ready rises
    for (int v = 21; v <= 40; v++) exp_b_q.push_back(e16(v));
    for (int v = 21; v <= 29; v++) b_send(s36(longint'(v) <<< 15), 1'b0);
    for (int v = 30; v <= 40; v++) b_send(s36(longint'(v) <<< 15), 1'b1);
    b_idle(1, 1'b1);
    wait_drain_b(60);
    b_idle(3, 1'b1);
    check("b_fullpop_ovf",   b_overflow,  0);
    check("b_fullpop_idle",  b_out_valid, 0);
    check("b_final_satcnt",  b_sat_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_output_conditioner.md
Name: fir_output_conditioner

Overview:
Sink-side partner of the 16-tap weighted FIR. It takes the FIR's 36-bit signed full-precision sum, rounds and saturates it back to 16-bit Q1.15, and discards the pipeline-fill warm-up samples. It then decimates by a fixed factor and buffers results in a small FIFO with a valid/ready output. The FIR cannot stall, so overflow is detected and flagged, never back-pressured.

Parameters:
DECIM, 4, keep 1 of every DECIM post-warm-up samples (1 = no decimation; legal 1..256)
WARMUP, 15, number of valid inputs discarded after reset (FIR taps minus 1; legal 0..255)
FIFO_DEPTH, 8, output FIFO entries (power of 2, >=2)
IN_W, 36, input sample width (signed)
OUT_W, 16, output sample width (signed)
FRAC_SHIFT, 15, right shift from Q2.30 product domain to Q1.15

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  in_sample is meaningful this cycle
in_sample  in  IN_W  signed FIR sum
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_sample  out  OUT_W  signed rounded/saturated sample (FIFO head)
overflow  out  1  sticky: a kept sample was dropped because the FIFO was full
sat_count  out  16  number of kept samples that saturated; sticks at 0xFFFF
status_clr  in  1  synchronous clear of overflow and sat_count

Behaviour:
- Reset (async, rst=1): warm-up count=0, decimation phase=0, stage-1 valid=0, FIFO empty, out_valid=0, out_sample=0, overflow=0, sat_count=0.
- Warm-up: the first WARMUP cycles with in_valid=1 are discarded, with no other effect. Afterwards the warm-up counter holds.
- Decimation: a post-warm-up valid input is kept when phase==0. The phase increments on every post-warm-up valid input and wraps from DECIM-1 to 0. The first post-warm-up sample is therefore always kept. in_valid=0 freezes both counters.
- Rounding: r = (in_sample + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT (arithmetic; round half toward +inf). Compute the add in IN_W+1 bits so it cannot wrap.
- Saturation: r>32767 gives 32767; r<-32768 gives -32768. A clamp on a kept sample increments sat_count (saturating); discarded samples never count.
- Stage 1: kept sample plus its sat flag are registered at the edge where it is presented (edge k).
- FIFO write happens at edge k+1, so out_valid rises after edge k+1. Latency from input to out_valid is 2 cycles with the FIFO empty.
- FIFO is show-ahead: out_sample = head entry whenever out_valid=1. A pop occurs on out_valid & out_ready. out_sample holds its last value when the FIFO is empty.
- Full FIFO with a simultaneous pop: the write proceeds and occupancy is unchanged.
- Full FIFO without a pop: the stage-1 sample is dropped, overflow is set and sticks, and FIFO contents are untouched. sat_count still counts a saturated dropped sample.
- Empty FIFO: out_ready is ignored.
- status_clr has priority over a same-cycle increment or set. Counters and flags are cleared; the increment or set is lost.
- rst asserted mid-stream flushes the FIFO and stage 1 and restarts the warm-up.
- No combinational path from in_* to out_* or from out_ready to out_valid.

Decomposition:
- Shared package fir_pkg: FIR_TAPS=16, SAMPLE_W=16, ACC_W=36, FRAC_SHIFT=15, SAT_MAX/SAT_MIN constants, and a rounding/saturation function reused by future FIR variants.
- One natural sub-module: fir_sync_fifo (parameterised width/depth, show-ahead, full/empty, simultaneous push+pop on full allowed). The top level holds the counters, the rounding/saturation logic and stage 1.

Test Plan:
- Warm-up and decimation: WARMUP=15, DECIM=4, drive in_sample=n<<15 for n=0..39 continuously with out_ready=1. Outputs must be 15,19,23,27,31,35,39, with the first appearing 2 cycles after input n=15.
- Rounding (DECIM=1, WARMUP=0): inputs 16383, 16384, -16384, -16385, 49152. Outputs must be 0, 1, 0, -1, 2, with sat_count=0.
- Saturation: inputs 2^30 and -2^30-32768. Outputs must be 32767 and -32768, sat_count=2. Input -2^30 gives -32768 with no count. Then pulse status_clr: sat_count=0.
- Overflow: FIFO_DEPTH=8, out_ready=0, DECIM=1, 10 kept samples 1..10. The FIFO must hold 1..8, overflow=1. Raising out_ready must drain 1..8 only.
- Full with pop: the FIFO is full and out_ready=1 on the same cycle a kept sample arrives. The sample is enqueued, overflow stays 0, and the stream is gap-free.
- Reset mid-stream: assert rst asynchronously (between edges) with 5 entries queued and phase=2. out_valid drops immediately. After release, WARMUP inputs are discarded again and the phase restarts at 0.
